fpcvt_round_pipe: RTL and testbench
===================================

// Module: fpcvt_round_pipe
// PURPOSE
//  Pipelined, parametrised linear-to-float converter: signed two's-complement sample -> sign/exponent/significand.
//  Value = (-1)^sign * sig * 2^exp; integrates normalise and round, with a per-transaction rounding mode.
//  Valid/ready handshake on both sides, 1 result/cycle throughput; sits between sample source and float consumer.
// PARAMETERS
//  D_W   12  input width (two's complement)
//  E_W   3   exponent width; E_MAX = 2^E_W-1
//  M_W   4   significand width
//  Legal only if D_W-1-M_W <= E_MAX and M_W >= 2 (elaboration-time check, $error otherwise)
// PORTS
//  clk          in   1    rising-edge clock
//  rst          in   1    synchronous, active-high reset
//  in_valid     in   1    input transaction offered
//  in_ready     out  1    block accepts input this cycle
//  in_data      in   D_W  signed sample
//  in_rmode     in   2    0=round-half-up, 1=truncate, 2=round-half-even, 3=treated as truncate
//  out_valid    out  1    result available
//  out_ready    in   1    consumer accepts result
//  out_sign     out  1    sign of in_data
//  out_exp      out  E_W  exponent
//  out_sig      out  M_W  significand
//  out_inexact  out  1    result != |in_data| (any discarded bit nonzero, or saturated)
//  out_sat      out  1    magnitude clamped (most-negative input, or round carry at E_MAX)
// BEHAVIOUR
//  Handshake: transfer when valid&ready. out_* stable while out_valid&~out_ready. No loss, no duplicate, order kept.
//  Pipeline: S1 sign/magnitude, S2 normalise, S3 round. Each stage holds valid bit v1..v3.
//   stage k advances when next stage empty or next stage advancing; S3 advances on ~v3|out_ready.
//   in_ready = ~v1 | S1 advancing (combinational from out_ready allowed). Latency 3 cycles unstalled.
//   Up to 3 results buffered under backpressure; in_ready low only when all 3 full and out_ready low.
//  S1: sign = in_data[D_W-1]; mag = |in_data| as D_W-1 bits; in_data = -2^(D_W-1) -> mag = all ones, sat=1.
//  S2: p = index of leading one of mag.
//   p < M_W (incl. mag=0): exp=0, sig=mag[M_W-1:0], R=0, S=0.
//   else exp = p-M_W+1, sig = mag[p:p-M_W+1], R = mag[p-M_W], S = OR(mag[p-M_W-1:0]) (0 if none).
//  S3: inc = mode0: R; mode2: R&(S|sig[0]); mode1/3: 0.
//   inc & sig!=all ones: sig+1, exp unchanged.
//   inc & sig==all ones & exp<E_MAX: sig = 1 followed by zeros (2^(M_W-1)), exp+1.
//   inc & sig==all ones & exp==E_MAX: sig, exp unchanged, sat=1.
//   inexact = R|S|sat (also 1 when truncated bits discarded).
//   in_rmode is captured with in_data and travels with it; changing it mid-stream affects only new inputs.
//  Reset: v1..v3=0, out_valid=0, in_ready=0 during rst, 1 the cycle after;
//   out_sign/exp/sig/inexact/sat = 0. In-flight data discarded; no partial result emitted after rst.
//  Simultaneous accept+emit with full pipe: allowed, occupancy unchanged.
// TESTING (D_W=12,E_W=3,M_W=4)
//  in=5, mode0 -> sign0 exp0 sig0101 inexact0 sat0 after exactly 3 cycles.
//  in=422 mode0 -> exp5 sig1101 inexact1 sat0; in=-422 -> same with sign1.
//  in=125 mode0 -> carry: exp4 sig1000 inexact1; mode1 -> exp3 sig1111 inexact1.
//  in=42: mode0 -> exp2 sig1011; mode2 -> exp2 sig1010 (tie to even); both inexact1.
//  in=2047 mode0 -> exp7 sig1111 sat1; in=-2048 -> sign1 exp7 sig1111 sat1 inexact1.
//  Backpressure: 5 back-to-back inputs, out_ready=0 for 4 cycles -> in_ready falls after 3 accepted,
//   all 5 results emitted in order, none lost; rst asserted with 2 in flight -> out_valid=0 next cycle, none emitted.

Source files
------------

// File: rtl/fpcvt_round_pipe_if.sv
// Handshake bundle for the linear-to-float converter: sample input side and
// float result side, each with its own valid/ready pair.
interface fpcvt_round_pipe_if #(
  parameter int D_W = 12,
  parameter int E_W = 3,
  parameter int M_W = 4
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic signed [D_W-1:0] in_data;
  logic [1:0]            in_rmode;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_sign;
  logic [E_W-1:0]        out_exp;
  logic [M_W-1:0]        out_sig;
  logic                  out_inexact;
  logic                  out_sat;

  // Producer of samples / consumer of results (the environment)
  modport master (
    output in_valid, in_data, in_rmode, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_sig, out_inexact, out_sat
  );

  // The converter itself
  modport slave (
    input  in_valid, in_data, in_rmode, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_sig, out_inexact, out_sat
  );
endinterface

// File: rtl/fpcvt_round_pipe.sv
// Three-stage linear-to-float converter: signed sample -> sign / exponent /
// significand with selectable rounding. Value = (-1)^sign * sig * 2^exp.
// Each stage carries its own valid bit and stalls only when the stage ahead
// is full and not draining, so the pipe buffers up to three results.
module fpcvt_round_pipe #(
  parameter int D_W = 12,
  parameter int E_W = 3,
  parameter int M_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  fpcvt_round_pipe_if.slave bus
);
  localparam int MAG_W = D_W - 1;
  localparam int E_MAX = (1 << E_W) - 1;

  typedef struct packed {
    logic [E_W-1:0] exp;
    logic [M_W-1:0] sig;
    logic           sat;
  } rnd_t;

  // The exponent must be able to express the largest normalising shift.
  if ((D_W - 1 - M_W > E_MAX) || (M_W < 2) || (MAG_W < M_W)) begin : g_bad_params
    $error("fpcvt_round_pipe: illegal parameter combination D_W=%0d E_W=%0d M_W=%0d", D_W, E_W, M_W);
  end

  // |x| in D_W-1 bits; the most-negative value is special-cased by the caller
  function automatic logic [MAG_W-1:0] abs_mag(input logic signed [D_W-1:0] x);
    logic signed [D_W-1:0] n;
    n = x[D_W-1] ? -x : x;
    return n[MAG_W-1:0];
  endfunction

  // Position of the most significant set bit, -1 when the magnitude is zero
  function automatic int msb_idx(input logic [MAG_W-1:0] m);
    int idx;
    idx = -1;
    for (int i = 0; i < MAG_W; i++) begin
      if (m[i]) idx = i;
    end
    return idx;
  endfunction

  // Round-increment decision; modes 1 and 3 both truncate
  function automatic logic round_inc(input logic [1:0] mode, input logic r,
                                     input logic s, input logic lsb);
    logic inc;
    case (mode)
      2'd0:    inc = r;
      2'd2:    inc = r & (s | lsb);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  // Apply the increment; a carry out renormalises, or saturates at the top exponent
  function automatic rnd_t round_apply(input logic [E_W-1:0] e, input logic [M_W-1:0] sig,
                                       input logic inc, input logic sat_in);
    rnd_t res;
    res.exp = e;
    res.sig = sig;
    res.sat = sat_in;
    if (inc) begin
      if (sig != '1) begin
        res.sig = sig + 1'b1;
      end else if (e != E_W'(E_MAX)) begin
        res.sig = {1'b1, {(M_W-1){1'b0}}};
        res.exp = e + 1'b1;
      end else begin
        res.sat = 1'b1;
      end
    end
    return res;
  endfunction

  logic ld1, ld2, ld3;
  logic vld_p1, vld_p2, vld_p3;
  logic in_is_min;

  logic             sign_p1;
  logic [MAG_W-1:0] mag_p1;
  logic             sat_p1;
  logic [1:0]       rmode_p1;

  logic             sign_p2;
  logic [E_W-1:0]   exp_p2;
  logic [M_W-1:0]   sig_p2;
  logic             rnd_p2;
  logic             stk_p2;
  logic             sat_p2;
  logic [1:0]       rmode_p2;

  logic             sign_p3;
  logic [E_W-1:0]   exp_p3;
  logic [M_W-1:0]   sig_p3;
  logic             inexact_p3;
  logic             sat_p3;

  int               lead;
  int               shamt;
  logic [E_W-1:0]   norm_exp;
  logic [M_W-1:0]   norm_sig;
  logic             norm_r;
  logic             norm_s;
  logic             inc_p2;
  rnd_t             rres;

  assign ld3       = ~vld_p3 | bus.out_ready;
  assign ld2       = ~vld_p2 | ld3;
  assign ld1       = ~vld_p1 | ld2;
  assign in_is_min = (bus.in_data == {1'b1, {(D_W-1){1'b0}}});

  assign bus.in_ready    = ~rst & ld1;
  assign bus.out_valid   = vld_p3;
  assign bus.out_sign    = sign_p3;
  assign bus.out_exp     = exp_p3;
  assign bus.out_sig     = sig_p3;
  assign bus.out_inexact = inexact_p3;
  assign bus.out_sat     = sat_p3;

  // Stage valid bits advance together with the stall chain
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      if (ld1) vld_p1 <= bus.in_valid;
      if (ld2) vld_p2 <= vld_p1;
      if (ld3) vld_p3 <= vld_p2;
    end
  end

  // ---- stage 1: sign / magnitude ----
  // Capture sign, magnitude and rounding mode of an accepted sample
  always_ff @(posedge clk) begin
    if (ld1 && bus.in_valid) begin
      sign_p1  <= bus.in_data[D_W-1];
      rmode_p1 <= bus.in_rmode;
      if (in_is_min) begin
        mag_p1 <= '1;
        sat_p1 <= 1'b1;
      end else begin
        mag_p1 <= abs_mag(bus.in_data);
        sat_p1 <= 1'b0;
      end
    end
  end

  // ---- stage 2: normalise ----
  // Locate the leading one and split the magnitude into sig / round / sticky
  always_comb begin
    lead   = msb_idx(mag_p1);
    shamt  = (lead < M_W) ? 0 : lead - M_W + 1;
    norm_r = 1'b0;
    norm_s = 1'b0;
    for (int i = 0; i < MAG_W; i++) begin
      if (i == shamt - 1) norm_r = mag_p1[i];
      if (i <  shamt - 1) norm_s = norm_s | mag_p1[i];
    end
    norm_sig = M_W'(mag_p1 >> shamt);
    norm_exp = E_W'(shamt);
  end

  // Register the normalised fields
  always_ff @(posedge clk) begin
    if (ld2 && vld_p1) begin
      sign_p2  <= sign_p1;
      exp_p2   <= norm_exp;
      sig_p2   <= norm_sig;
      rnd_p2   <= norm_r;
      stk_p2   <= norm_s;
      sat_p2   <= sat_p1;
      rmode_p2 <= rmode_p1;
    end
  end

  // ---- stage 3: round ----
  // Decide the increment and apply carry / saturation
  always_comb begin
    inc_p2 = round_inc(rmode_p2, rnd_p2, stk_p2, sig_p2[0]);
    rres   = round_apply(exp_p2, sig_p2, inc_p2, sat_p2);
  end

  // Output register; cleared on reset and held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_p3    <= 1'b0;
      exp_p3     <= '0;
      sig_p3     <= '0;
      inexact_p3 <= 1'b0;
      sat_p3     <= 1'b0;
    end else if (ld3 && vld_p2) begin
      sign_p3    <= sign_p2;
      exp_p3     <= rres.exp;
      sig_p3     <= rres.sig;
      inexact_p3 <= rnd_p2 | stk_p2 | rres.sat;
      sat_p3     <= rres.sat;
    end
  end
endmodule

// File: tb/tb_fpcvt_round_pipe.sv
// Bench for fpcvt_round_pipe: table vectors, latency, backpressure, reset
// flush and a randomised handshake phase, all checked through a scoreboard.
module tb_fpcvt_round_pipe;
  typedef struct packed {
    logic       sign;
    logic [2:0] exp;
    logic [3:0] sig;
    logic       inexact;
    logic       sat;
  } res_t;

  typedef struct {
    logic signed [11:0] d;
    logic [1:0]         m;
    res_t               e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  res_t sb[$];
  res_t held;
  bit   held_v = 1'b0;
  vec_t tbl[19];

  fpcvt_round_pipe_if #(.D_W(12), .E_W(3), .M_W(4)) bus ();

  fpcvt_round_pipe #(.D_W(12), .E_W(3), .M_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  function automatic vec_t mk(int d, int m, bit s, int e, int g, bit i, bit t);
    vec_t v;
    v.d = 12'(d);
    v.m = 2'(m);
    v.e = {s, 3'(e), 4'(g), i, t};
    return v;
  endfunction

  // Arithmetic reference: exponent = smallest shift fitting 4 bits, remainder drives rounding
  function automatic res_t model(logic signed [11:0] d, logic [1:0] m);
    res_t r;
    int   mag, e, q, rem, half;
    bit   up, sat;
    sat = 1'b0;
    if (d == -2048) begin
      mag = 2047;
      sat = 1'b1;
    end else begin
      mag = (d < 0) ? -int'(d) : int'(d);
    end
    e = 0;
    while ((mag >> e) >= 16) e++;
    q    = mag >> e;
    rem  = mag - (q << e);
    half = (e > 0) ? (1 << (e - 1)) : 0;
    up   = 1'b0;
    if (e > 0) begin
      if (m == 2'd0) up = (rem >= half);
      else if (m == 2'd2) up = (rem > half) || ((rem == half) && q[0]);
    end
    if (up) begin
      if (q == 15) begin
        if (e < 7) begin
          q = 8;
          e++;
        end else begin
          sat = 1'b1;
        end
      end else begin
        q++;
      end
    end
    r.sign    = d[11];
    r.exp     = 3'(e);
    r.sig     = 4'(q);
    r.sat     = sat;
    r.inexact = (rem != 0) || sat;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_res(input string name, input res_t got, input res_t req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s actual sign=%0d exp=%0d sig=%b inexact=%0d sat=%0d required sign=%0d exp=%0d sig=%b inexact=%0d sat=%0d",
               name, got.sign, got.exp, got.sig, got.inexact, got.sat,
               req.sign, req.exp, req.sig, req.inexact, req.sat);
    end
  endtask

  task automatic check_out();
    res_t got;
    got = {bus.out_sign, bus.out_exp, bus.out_sig, bus.out_inexact, bus.out_sat};
    n_out++;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_output actual=%h required none", got);
    end else begin
      chk_res("result", got, sb.pop_front());
    end
  endtask

  // One clock: drive at the falling edge, then observe the settled handshake
  task automatic step(input bit r, input bit iv, input logic signed [11:0] d,
                      input logic [1:0] m, input bit ordy, input res_t e, output bit acc);
    res_t cur;
    @(negedge clk);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_rmode  = m;
    bus.out_ready = ordy;
    #1;
    acc = 1'b0;
    cur = {bus.out_sign, bus.out_exp, bus.out_sig, bus.out_inexact, bus.out_sat};
    if (held_v && bus.out_valid) chk_res("stall_stable", cur, held);
    held   = cur;
    held_v = !r && bus.out_valid && !bus.out_ready;
    if (!r && bus.out_valid && bus.out_ready) check_out();
    if (!r && iv && bus.in_ready) begin
      acc = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    step(1'b0, 1'b0, 12'sd0, 2'd0, ordy, '0, acc);
  endtask

  task automatic send(input logic signed [11:0] d, input logic [1:0] m, input res_t e);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b0, 1'b1, d, m, 1'b1, e, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("send_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      idle(1'b1);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    bit               acc;
    bit               have;
    int               n, cnt, sent, emitted;
    logic signed [11:0] d;
    logic [1:0]       m;
    logic signed [11:0] bp[5];

    tbl[0]  = mk(5,     0, 0, 0, 4'b0101, 0, 0);
    tbl[1]  = mk(422,   0, 0, 5, 4'b1101, 1, 0);
    tbl[2]  = mk(-422,  0, 1, 5, 4'b1101, 1, 0);
    tbl[3]  = mk(125,   0, 0, 4, 4'b1000, 1, 0);
    tbl[4]  = mk(125,   1, 0, 3, 4'b1111, 1, 0);
    tbl[5]  = mk(42,    0, 0, 2, 4'b1011, 1, 0);
    tbl[6]  = mk(42,    2, 0, 2, 4'b1010, 1, 0);
    tbl[7]  = mk(2047,  0, 0, 7, 4'b1111, 1, 1);
    tbl[8]  = mk(-2048, 0, 1, 7, 4'b1111, 1, 1);
    tbl[9]  = mk(0,     0, 0, 0, 4'b0000, 0, 0);
    tbl[10] = mk(-1,    0, 1, 0, 4'b0001, 0, 0);
    tbl[11] = mk(15,    0, 0, 0, 4'b1111, 0, 0);
    tbl[12] = mk(16,    0, 0, 1, 4'b1000, 0, 0);
    tbl[13] = mk(17,    0, 0, 1, 4'b1001, 1, 0);
    tbl[14] = mk(17,    2, 0, 1, 4'b1000, 1, 0);
    tbl[15] = mk(19,    2, 0, 1, 4'b1010, 1, 0);
    tbl[16] = mk(125,   3, 0, 3, 4'b1111, 1, 0);
    tbl[17] = mk(2047,  1, 0, 7, 4'b1111, 1, 0);
    tbl[18] = mk(31,    0, 0, 2, 4'b1000, 1, 0);

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_rmode  = '0;
    bus.out_ready = 1'b0;

    // reset state
    step(1'b1, 1'b0, 12'sd0, 2'd0, 1'b1, '0, acc);
    step(1'b1, 1'b1, 12'sd5, 2'd0, 1'b1, '0, acc);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_outputs", {bus.out_sign, bus.out_exp, bus.out_sig, bus.out_inexact, bus.out_sat}, 0);
    idle(1'b1);
    chk("post_rst_in_ready", bus.in_ready, 1);

    // latency of a single result through an empty pipe
    send(12'sd5, 2'd0, tbl[0].e);
    n = 0;
    do begin
      idle(1'b1);
      n++;
    end while (!bus.out_valid && n < 10);
    chk("latency", n, 3);
    drain();

    // table vectors back to back
    for (int i = 0; i < 19; i++) send(tbl[i].d, tbl[i].m, tbl[i].e);
    drain();

    // backpressure: five inputs, consumer stalled for four cycles
    bp[0] = 12'sd100; bp[1] = -12'sd77; bp[2] = 12'sd1500; bp[3] = 12'sd9; bp[4] = -12'sd1023;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1, bp[cnt], 2'd0, 1'b0, model(bp[cnt], 2'd0), acc);
      if (acc) cnt++;
      if (c == 3) chk("bp_in_ready_low", bus.in_ready, 0);
    end
    chk("bp_accepted", cnt, 3);
    n = 0;
    while (cnt < 5 && n < 20) begin
      step(1'b0, 1'b1, bp[cnt], 2'd0, 1'b1, model(bp[cnt], 2'd0), acc);
      if (acc) cnt++;
      n++;
    end
    chk("bp_all_accepted", cnt, 5);
    drain();

    // reset with two transactions in flight
    send(12'sd300, 2'd0, model(12'sd300, 2'd0));
    send(-12'sd300, 2'd2, model(-12'sd300, 2'd2));
    step(1'b1, 1'b0, 12'sd0, 2'd0, 1'b0, '0, acc);
    sb.delete();
    emitted = n_out;
    idle(1'b1);
    chk("flush_out_valid", bus.out_valid, 0);
    for (int c = 0; c < 6; c++) idle(1'b1);
    chk("flush_none_emitted", n_out - emitted, 0);

    // randomised traffic with random consumer stalls and mixed modes
    have = 1'b0;
    sent = 0;
    d    = '0;
    m    = '0;
    for (int c = 0; c < 400 && sent < 60; c++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        d    = 12'($urandom_range(0, 4095));
        m    = 2'($urandom_range(0, 3));
        have = 1'b1;
      end
      step(1'b0, have, d, m, ($urandom_range(0, 3) != 0), model(d, m), acc);
      if (acc) begin
        have = 1'b0;
        sent++;
      end
    end
    chk("rand_sent", sent, 60);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
